// File: rtl/flag_stack_reg.sv
// flag_stack_reg: processor-status flag register with a save/restore stack.
//
// Holds WIDTH flag bits that accept masked partial writes from the ALU and
// single-cycle set/clear strobes (clear wins over set). A DEPTH-entry stack
// lets the control FSM save r on interrupt/call entry (push) and restore it
// on return (pop). Overflow/underflow attempts raise sticky error flags.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   D_in     write data from ALU
//   wEnable  masked write strobe
//   wMask    per-bit write mask (1 = bit takes D_in)
//   setMask  bits forced to 1 this cycle
//   clrMask  bits forced to 0 this cycle (wins over setMask)
//   push     save current r onto stack
//   pop      restore r from top of stack (overrides write/set/clear)
//   err_clr  clear sticky error flags (a same-cycle error event wins)
//   r        current flag register
//   depth    number of occupied stack entries
//   full     depth == DEPTH
//   empty    depth == 0
//   err_ovf  sticky: push attempted while full
//   err_unf  sticky: pop attempted while empty
module flag_stack_reg #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             D_in,
  input  logic                         wEnable,
  input  logic [WIDTH-1:0]             wMask,
  input  logic [WIDTH-1:0]             setMask,
  input  logic [WIDTH-1:0]             clrMask,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         err_clr,
  output logic [WIDTH-1:0]             r,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         full,
  output logic                         empty,
  output logic                         err_ovf,
  output logic                         err_unf
);

  localparam int unsigned   DW   = $clog2(DEPTH + 1);
  localparam int unsigned   AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DEPTH);

  logic [WIDTH-1:0] stack [DEPTH];

  logic             push_eff;
  logic             pop_eff;
  logic             ovf_evt;
  logic             unf_evt;
  logic [WIDTH-1:0] w_val;
  logic [WIDTH-1:0] upd_val;
  logic [WIDTH-1:0] r_next;
  logic [DW-1:0]    depth_next;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  always_comb begin
    push_eff   = push & ~pop & ~full;
    pop_eff    = pop & ~push & ~empty;
    ovf_evt    = push & ~pop & full;
    unf_evt    = pop & ~push & empty;

    // Indices are only used when the matching operation is effective,
    // so the truncation to AW bits never drops a set bit.
    wr_idx     = AW'(depth);
    rd_idx     = AW'(depth - DW'(1));

    w_val      = wEnable ? ((r & ~wMask) | (D_in & wMask)) : r;
    upd_val    = (w_val | setMask) & ~clrMask;
    r_next     = pop_eff ? stack[rd_idx] : upd_val;

    depth_next = depth;
    if (push_eff)
      depth_next = depth + DW'(1);
    else if (pop_eff)
      depth_next = depth - DW'(1);
  end

  // Stack storage carries no reset; it is only observable through a pop,
  // which requires a prior push after the last reset.
  always_ff @(posedge clk) begin
    if (push_eff)
      stack[wr_idx] <= r;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r       <= RESET_VAL;
      depth   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      r       <= r_next;
      depth   <= depth_next;
      full    <= (depth_next == DMAX);
      empty   <= (depth_next == '0);
      err_ovf <= ovf_evt | (err_ovf & ~err_clr);
      err_unf <= unf_evt | (err_unf & ~err_clr);
    end
  end

endmodule
